// File: rtl/cpu_core_seq_if.sv
// Memory-side bus of the sequential Nandgame core: an instruction-fetch
// channel and a data channel, each a req/ack handshake.
interface cpu_core_seq_if #(
    parameter int W  = 16,
    parameter int AW = 16
);
    // Instruction fetch channel
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [W-1:0]  i_data;
    logic          i_ack;

    // Data (*A) channel
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [W-1:0]  d_wdata;
    logic [W-1:0]  d_rdata;
    logic          d_ack;

    // Core side
    modport master (
        output i_req, i_addr,
        input  i_data, i_ack,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack
    );

    // Memory side
    modport slave (
        input  i_req, i_addr,
        output i_data, i_ack,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack
    );
endinterface

// File: rtl/cpu_core_seq.sv
// Multi-cycle Nandgame-style CPU core. Owns A, D and pc; fetches one
// instruction at a time and performs at most one *A read (LOAD) and one
// *A write (STORE) per instruction, tolerating any number of wait states.
module cpu_core_seq #(
    parameter int W  = 16,
    parameter int AW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    cpu_core_seq_if.master        bus,
    output logic [AW-1:0]         pc,
    output logic [W-1:0]          reg_a,
    output logic [W-1:0]          reg_d,
    output logic                  retire
);
    typedef enum logic [1:0] {S_FETCH, S_LOAD, S_EXEC, S_STORE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  ir_q, ir_d;
    logic [W-1:0]  mem_q, mem_d;    // *A captured during LOAD
    logic [W-1:0]  r_q, r_d;        // ALU result held across STORE
    logic          jmp_q, jmp_d;    // jump decision held across STORE
    logic          fpend_q, fpend_d; // fetch issued but not yet acked

    // Decoded instruction fields
    logic ci, f_sm, f_u, f_op1, f_op0, f_zx, f_sw;
    logic f_a, f_d, f_st, f_lt, f_eq, f_gt;

    assign ci    = ir_q[W-1];
    assign f_sm  = ir_q[12];
    assign f_u   = ir_q[10];
    assign f_op1 = ir_q[9];
    assign f_op0 = ir_q[8];
    assign f_zx  = ir_q[7];
    assign f_sw  = ir_q[6];
    assign f_a   = ir_q[5];
    assign f_d   = ir_q[4];
    assign f_st  = ir_q[3];
    assign f_lt  = ir_q[2];
    assign f_eq  = ir_q[1];
    assign f_gt  = ir_q[0];

    logic [W-1:0]  alu_x, alu_y, y_src, alu_r;
    logic          alu_jmp;
    logic [AW-1:0] pc_inc;
    logic          i_req_c, d_req_c, d_we_c, retire_c;

    assign pc_inc = pc_q + AW'(1);

    // ALU operand routing, function select and jump condition
    always_comb begin
        y_src = f_sm ? mem_q : a_q;
        alu_x = f_sw ? y_src : d_q;
        alu_y = f_sw ? d_q : y_src;
        if (f_zx) begin
            alu_x = '0;
        end
        case ({f_u, f_op1, f_op0})
            3'b100:  alu_r = alu_x + alu_y;
            3'b101:  alu_r = alu_x + W'(1);
            3'b110:  alu_r = alu_x - alu_y;
            3'b111:  alu_r = alu_x - W'(1);
            3'b000:  alu_r = alu_x & alu_y;
            3'b001:  alu_r = alu_x | alu_y;
            3'b010:  alu_r = alu_x ^ alu_y;
            default: alu_r = ~alu_x;
        endcase
        alu_jmp = (f_lt & alu_r[W-1])
                | (f_eq & (alu_r == '0))
                | (f_gt & ~alu_r[W-1] & (alu_r != '0));
    end

    // Next-state, handshake outputs and writeback commit
    always_comb begin
        logic          commit;
        logic [W-1:0]  wb_r;
        logic          wb_j;
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        d_d      = d_q;
        ir_d     = ir_q;
        mem_d    = mem_q;
        r_d      = r_q;
        jmp_d    = jmp_q;
        fpend_d  = 1'b0;
        i_req_c  = 1'b0;
        d_req_c  = 1'b0;
        d_we_c   = 1'b0;
        retire_c = 1'b0;
        commit   = 1'b0;
        // STORE commits the values latched in EXEC; EXEC commits directly.
        wb_r     = (state_q == S_STORE) ? r_q : alu_r;
        wb_j     = (state_q == S_STORE) ? jmp_q : alu_jmp;

        case (state_q)
            S_FETCH: begin
                // Once issued, a fetch stays up until acked even if run drops.
                if (!rst && (run || fpend_q)) begin
                    i_req_c = 1'b1;
                    if (bus.i_ack) begin
                        ir_d    = bus.i_data;
                        state_d = (bus.i_data[W-1] && bus.i_data[12]) ? S_LOAD : S_EXEC;
                    end else begin
                        fpend_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                d_req_c = 1'b1;
                if (bus.d_ack) begin
                    mem_d   = bus.d_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!ci) begin
                    a_d      = ir_q;
                    pc_d     = pc_inc;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (f_st) begin
                    r_d     = alu_r;
                    jmp_d   = alu_jmp;
                    state_d = S_STORE;
                end else begin
                    commit = 1'b1;
                end
            end
            default: begin // S_STORE
                d_req_c = 1'b1;
                d_we_c  = 1'b1;
                if (bus.d_ack) begin
                    commit = 1'b1;
                end
            end
        endcase

        // Jump target is always the A value from before this instruction.
        if (commit) begin
            if (f_a) begin
                a_d = wb_r;
            end
            if (f_d) begin
                d_d = wb_r;
            end
            pc_d     = wb_j ? a_q[AW-1:0] : pc_inc;
            retire_c = 1'b1;
            state_d  = S_FETCH;
        end
    end

    // State and architectural registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            mem_q   <= '0;
            r_q     <= '0;
            jmp_q   <= 1'b0;
            fpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            mem_q   <= mem_d;
            r_q     <= r_d;
            jmp_q   <= jmp_d;
            fpend_q <= fpend_d;
        end
    end

    assign bus.i_req   = i_req_c;
    assign bus.i_addr  = pc_q;
    assign bus.d_req   = d_req_c;
    assign bus.d_we    = d_we_c;
    assign bus.d_addr  = a_q[AW-1:0];
    assign bus.d_wdata = r_q;

    assign pc     = pc_q;
    assign reg_a  = a_q;
    assign reg_d  = d_q;
    assign retire = retire_c;
endmodule

// File: tb/tb_cpu_core_seq.sv
// Directed bench for cpu_core_seq: acts as instruction ROM and data RAM,
// drives hand-picked instructions and checks registers, bus traffic and
// cycle counts against hand-computed values.
module tb_cpu_core_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] pc;
    logic [15:0] reg_a;
    logic [15:0] reg_d;
    logic        retire;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    cpu_core_seq_if #(.W(16), .AW(16)) bus ();

    cpu_core_seq #(.W(16), .AW(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .bus    (bus),
        .pc     (pc),
        .reg_a  (reg_a),
        .reg_d  (reg_d),
        .retire (retire)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one instruction: fetch, optional LOAD/STORE, until retire.
    task automatic exec_instr(input logic [15:0] instr, input int iwait, input int dwait,
                              input logic [15:0] rdata, output int cycles, output int dcyc,
                              output logic [15:0] ia, output logic [15:0] da,
                              output logic dwe, output logic [15:0] dwd);
        int iw = 0;
        int dw = 0;
        bit done = 1'b0;
        cycles = 0;
        dcyc   = 0;
        ia     = 16'h0;
        da     = 16'h0;
        dwe    = 1'b0;
        dwd    = 16'h0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            bus.i_ack = 1'b0;
            bus.d_ack = 1'b0;
            if (bus.i_req) begin
                if (cycles == 0) ia = bus.i_addr;
                if (iw == iwait) begin
                    bus.i_ack  = 1'b1;
                    bus.i_data = instr;
                end else begin
                    iw++;
                end
            end
            if (bus.d_req) begin
                if (dcyc == 0) begin
                    da  = bus.d_addr;
                    dwe = bus.d_we;
                    dwd = bus.d_wdata;
                end else begin
                    check("d_addr_stable", bus.d_addr, da);
                    check("d_we_stable", bus.d_we, dwe);
                    check("d_wdata_stable", bus.d_wdata, dwd);
                end
                dcyc++;
                if (dw == dwait) begin
                    bus.d_ack   = 1'b1;
                    bus.d_rdata = rdata;
                end else begin
                    dw++;
                end
            end
            cycles++;
            #1;
            if (retire) done = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.i_ack = 1'b0;
        bus.d_ack = 1'b0;
        check("retire_seen", done, 1'b1);
        $display("instr %h: cycles=%0d dcycles=%0d A=%h D=%h pc=%h", instr, cycles, dcyc, reg_a, reg_d, pc);
    endtask

    initial begin
        int          c;
        int          dc;
        logic [15:0] ia;
        logic [15:0] da;
        logic        dwe;
        logic [15:0] dwd;

        rst         = 1'b1;
        run         = 1'b0;
        bus.i_ack   = 1'b0;
        bus.d_ack   = 1'b0;
        bus.i_data  = 16'h0;
        bus.d_rdata = 16'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_i_req", bus.i_req, 1'b0);
        check("rst_d_req", bus.d_req, 1'b0);
        check("rst_d_we", bus.d_we, 1'b0);
        check("rst_retire", retire, 1'b0);
        check("rst_pc", pc, 16'h0);
        check("rst_a", reg_a, 16'h0);
        check("rst_d", reg_d, 16'h0);
        check("rst_d_addr", bus.d_addr, 16'h0);
        check("rst_d_wdata", bus.d_wdata, 16'h0);

        // run=0: no fetch ever issued
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("idle_i_req", bus.i_req, 1'b0);
        end

        // run=1 held through reset: request rises right after reset ends
        rst = 1'b1;
        run = 1'b1;
        #1;
        check("rst_gates_i_req", bus.i_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_i_req", bus.i_req, 1'b1);
        check("first_i_addr", bus.i_addr, 16'h0);

        // Data instruction
        exec_instr(16'h04D2, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        check("ld_cycles", c, 2);
        check("ld_no_data", dc, 0);
        check("ld_a", reg_a, 16'h04D2);
        check("ld_pc", pc, 16'h0001);

        // A=7, D=9, then D = D+1 with zx -> 1
        exec_instr(16'h0009, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'hE490, 1, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        check("dA_wait_cycles", c, 3);
        check("dA_d", reg_d, 16'h0009);
        exec_instr(16'h0007, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'hE590, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        check("inc_cycles", c, 2);
        check("inc_no_data", dc, 0);
        check("inc_d", reg_d, 16'h0001);
        check("inc_a", reg_a, 16'h0007);
        check("inc_pc", pc, 16'h0005);

        // A=0, *A=0x2A: A = *A, jump to old A (0)
        exec_instr(16'h0000, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'hF4A3, 0, 0, 16'h002A, c, dc, ia, da, dwe, dwd);
        check("sm_cycles", c, 3);
        check("sm_dcyc", dc, 1);
        check("sm_addr", da, 16'h0000);
        check("sm_we", dwe, 1'b0);
        check("sm_a", reg_a, 16'h002A);
        check("sm_d", reg_d, 16'h0001);
        check("sm_pc_jump", pc, 16'h0000);

        // A=6, D=5: D,*A = D&A = 4, store acked after 3 wait cycles
        exec_instr(16'h0005, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'hE490, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'h0006, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'hE018, 0, 3, 16'h0, c, dc, ia, da, dwe, dwd);
        check("st_cycles", c, 6);
        check("st_dcyc", dc, 4);
        check("st_addr", da, 16'h0006);
        check("st_we", dwe, 1'b1);
        check("st_wdata", dwd, 16'h0004);
        check("st_d", reg_d, 16'h0004);
        check("st_a", reg_a, 16'h0006);
        check("st_pc", pc, 16'h0004);

        // A=0x2A, D=1: A = A-1 with swap -> 0x29
        exec_instr(16'h0001, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'hE490, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'h002A, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        exec_instr(16'hE760, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        check("dec_cycles", c, 2);
        check("dec_a", reg_a, 16'h0029);
        check("dec_d", reg_d, 16'h0001);
        check("dec_pc", pc, 16'h0008);

        // A = -1, unconditional jump to 0xFFFF, then pc wraps to 0
        exec_instr(16'hE7A0, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        check("m1_a", reg_a, 16'hFFFF);
        check("m1_pc", pc, 16'h0009);
        exec_instr(16'hE087, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        check("jmp_pc", pc, 16'hFFFF);
        exec_instr(16'h0003, 0, 0, 16'h0, c, dc, ia, da, dwe, dwd);
        check("wrap_fetch_addr", ia, 16'hFFFF);
        check("wrap_pc", pc, 16'h0000);
        check("wrap_a", reg_a, 16'h0003);

        // run drops while a fetch is outstanding: instruction completes, then halt
        @(negedge clk);
        check("pend_i_req", bus.i_req, 1'b1);
        @(negedge clk);
        run = 1'b0;
        #1;
        check("pend_held_i_req", bus.i_req, 1'b1);
        bus.i_ack  = 1'b1;
        bus.i_data = 16'h0011;
        @(negedge clk);
        bus.i_ack = 1'b0;
        #1;
        check("pend_retire", retire, 1'b1);
        @(negedge clk);
        check("pend_a", reg_a, 16'h0011);
        check("pend_pc", pc, 16'h0001);
        $display("run dropped mid-fetch: A=%h pc=%h", reg_a, pc);

        // Halted: stray acks are ignored
        bus.i_ack   = 1'b1;
        bus.i_data  = 16'h0077;
        bus.d_ack   = 1'b1;
        bus.d_rdata = 16'h0055;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("halt_i_req", bus.i_req, 1'b0);
            check("halt_retire", retire, 1'b0);
        end
        check("stray_pc", pc, 16'h0001);
        check("stray_a", reg_a, 16'h0011);
        bus.i_ack = 1'b0;
        bus.d_ack = 1'b0;

        // Reset during a stalled LOAD
        run = 1'b1;
        #1;
        check("ld2_i_req", bus.i_req, 1'b1);
        bus.i_ack  = 1'b1;
        bus.i_data = 16'hF4A3;
        @(negedge clk);
        bus.i_ack = 1'b0;
        check("ld2_d_req", bus.d_req, 1'b1);
        check("ld2_d_we", bus.d_we, 1'b0);
        check("ld2_d_addr", bus.d_addr, 16'h0011);
        @(negedge clk);
        check("ld2_stall", bus.d_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_d_req", bus.d_req, 1'b0);
        check("abort_retire", retire, 1'b0);
        check("abort_a", reg_a, 16'h0000);
        check("abort_d", reg_d, 16'h0000);
        check("abort_pc", pc, 16'h0000);
        $display("reset mid-LOAD: d_req=%b A=%h D=%h pc=%h", bus.d_req, reg_a, reg_d, pc);
        run = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_abort_pc", pc, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_core_seq.md
# cpu_core_seq

Parametrised, multi-cycle Nandgame-style CPU core. It owns the A and D registers and the program counter, fetches instructions over a handshaked instruction port, and reads/writes `*A` over a handshaked data port. It replaces the purely combinational control-unit/register arrangement and tolerates memories with arbitrary wait states. It sits between instruction ROM and data RAM at the top of the computer.

## Interface

**Parameters**

- `W`, default 16: data, register and instruction width. Must be at least 16. Instruction control fields always occupy bits [12:0], and bit W-1 is `ci`.
- `AW`, default 16: address width of `pc`, `i_addr` and `d_addr`. Must be at most W. Addresses are taken from `A[AW-1:0]`.

**Ports** (clock and reset first)

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `run`  in  1  fetch enable; sampled only in FETCH before a request is issued.
- `i_req`  out  1  instruction read request.
- `i_addr`  out  AW  instruction address (equals `pc`).
- `i_data`  in  W  instruction word; valid when `i_ack` is high.
- `i_ack`  in  1  instruction read complete; may be high in the same cycle as `i_req`.
- `d_req`  out  1  data access request.
- `d_we`  out  1  1 = write, 0 = read.
- `d_addr`  out  AW  data address: the A value from before the current instruction.
- `d_wdata`  out  W  write data (R).
- `d_rdata`  in  W  read data; valid when `d_ack` is high.
- `d_ack`  in  1  data access complete; may be high in the same cycle as `d_req`.
- `pc`, `reg_a`, `reg_d`  out  AW/W/W  architectural state, for debug.
- `retire`  out  1  one-cycle pulse in the cycle in which an instruction's writeback is committed.

## Operation

**Decode** of the latched instruction register `ir`:

- `ci` = bit W-1. When `ci` = 0 the instruction is a data instruction: A ← `ir`.
- ALU fields: `sm`=12, `u`=10, `op1`=9, `op0`=8, `zx`=7, `sw`=6.
- Destination fields: `a`=5, `d`=4, `*a`=3.
- Jump fields: `lt`=2, `eq`=1, `gt`=0.
- Bits 14..13 and any bits between 13 and W-2 are ignored.

**ALU**

- Operands: X = D, Y = (`sm` ? `*A` : A). If `sw`, X and Y are swapped. Then, if `zx`, X = 0.
- `u`=1 (arithmetic), selected by `op1`,`op0`: 00 X+Y, 01 X+1, 10 X−Y, 11 X−1.
- `u`=0 (logic), selected by `op1`,`op0`: 00 X&Y, 01 X|Y, 10 X^Y, 11 ~X.
- All arithmetic wraps modulo 2^W.

**Jump condition**

- j = (`lt` & R[W-1]) | (`eq` & R==0) | (`gt` & !R[W-1] & R!=0).
- The jump target is the old `A[AW-1:0]`. Otherwise pc ← pc+1, wrapping modulo 2^AW.

**Writeback**

- R is written to every selected destination in the same cycle.
- `*a` writes use the old A as the address. The jump target is also the old A, even when A is itself a destination.

**FSM states**

- **FETCH**
  - If `run`=0: stay in FETCH with `i_req`=0.
  - Otherwise: `i_req`=1 with `i_addr`=pc, held stable until `i_ack`.
  - On `i_ack`: `ir` ← `i_data`, then go to LOAD if `ci` & `sm`, else go to EXEC.
- **LOAD**
  - `d_req`=1, `d_we`=0, `d_addr`=A, held until `d_ack`.
  - On `d_ack`: latch `d_rdata` as `*A`, then go to EXEC.
- **EXEC**
  - Data instruction: commit A ← `ir`, pc+1, `retire`; go to FETCH.
  - ALU instruction without `*a`: commit A/D/pc, `retire`; go to FETCH.
  - ALU instruction with `*a`: latch R and the jump decision; go to STORE.
- **STORE**
  - `d_req`=1, `d_we`=1, `d_addr`=old A, `d_wdata`=R, all held stable until `d_ack`.
  - On `d_ack`: commit A/D/pc, `retire`; go to FETCH.

Outputs `i_req` and `d_req` are registered-state decodes, never combinational from the acks.

## Timing

**Reset values:** state FETCH; `pc`=0, A=0, D=0, `ir`=0; `i_req`=0, `d_req`=0, `d_we`=0, `retire`=0; `d_addr`=0, `d_wdata`=0.

**First request:** `i_req` rises in the first cycle after `rst` deasserts, provided `run`=1.

**Latency with zero-wait acks**

- Data instruction, or ALU instruction with no `*A` access: 2 cycles.
- With a `sm` read: 3 cycles.
- Each `*a` write adds 1 cycle.
- Each wait cycle on an ack adds exactly 1 cycle.

**Throughput:** no overlap between instructions, and at most one `retire` per 2 cycles.

**Boundary conditions**

- `rst` asserted mid-LOAD or mid-STORE: the access is abandoned, the request drops on the next cycle, and no architectural state is committed.
- `run` deasserted while a request is outstanding: the current instruction completes, then the core halts in FETCH.
- An ack while the corresponding request is low is ignored.
- pc = 2^AW−1 with no jump: pc wraps to 0.

## Test plan

- Reset, then `ir`=16'h04D2 with zero-wait ack → after 2 cycles A=0x04D2, pc=1, one `retire`, `d_req` never asserted.
- A=7, D=9, `ir`=16'hE590 → D=0x0001, A=7, pc+1, 2 cycles, no data access.
- A=0, mem[0]=0x002A, `ir`=16'hF4A3 → LOAD at `d_addr`=0, then A=0x002A and the jump taken to pc=0 (old A), 3 cycles.
- A=6, D=5, `ir`=16'hE018, `d_ack` delayed 3 cycles → `d_req`/`d_we`=1, `d_addr`=6, `d_wdata`=4 held stable for 4 cycles, then D=4 and `retire` on the ack cycle.
- A=0x002A, D=1, `ir`=16'hE760 → A=0x0029; pc at 0xFFFF with no jump wraps to 0.
- `run`=0 after reset → `i_req` stays 0 indefinitely; `rst` pulsed during a stalled LOAD → next cycle `d_req`=0, A/D/pc unchanged at reset values.
